asynchronize_fifo: RTL and testbench

ASYNCHRONIZE_FIFO -- requirements
Module: asynchronize_fifo

---
 rtl/asynchronize_fifo.sv | 126 ++++++++++++
 tb/tb_asynchronize_fifo.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/asynchronize_fifo.sv
// ---------------------------------------------------------------------------
// asynchronize_fifo
//
// Single-clock first-word-fall-through FIFO. It has DEPTH = 2**ADDR_WIDTH
// entries. The oldest stored word is always visible on data_out, and r_en
// pops it.
//
// Parameters
//   DATA_WIDTH : word width in bits (default 8)
//   ADDR_WIDTH : log2 of the depth (default 3, giving 8 entries)
//
// Ports
//   clk        : clock; all state changes on its rising edge
//   rst        : synchronous active-high reset; clears pointers, not the array
//   w_en       : write request; accepted only while full = 0
//   r_en       : pop request; accepted only while empty = 0
//   data_in    : write data
//   data_out   : head-of-queue word; 0 while empty
//   full       : DEPTH words stored
//   empty      : no words stored
//   count      : fill level, 0..DEPTH
//
// Optional feature, enabled with macro ASYNCHRONIZE_FIFO_ERR_FLAGS_EN
//   overflow   : sticky; set by a write request while full
//   underflow  : sticky; set by a pop request while empty
//   Only rst clears these flags.
// ---------------------------------------------------------------------------
module asynchronize_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  w_en,
   input  logic                  r_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  full,
   output logic                  empty,
`ifdef ASYNCHRONIZE_FIFO_ERR_FLAGS_EN
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
`else
   output logic [ADDR_WIDTH:0]   count
`endif
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   // Storage array. The array is not reset: the pointers alone decide
   // which entries hold valid data.
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Each pointer carries one extra wrap bit above the array address.
   logic [ADDR_WIDTH:0]   wr_ptr_reg;
   logic [ADDR_WIDTH:0]   rd_ptr_reg;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  wr_accept;
   logic                  rd_accept;

   assign wr_addr = wr_ptr_reg[ADDR_WIDTH-1:0];
   assign rd_addr = rd_ptr_reg[ADDR_WIDTH-1:0];

   // The flags depend only on the registered pointers. When both requests
   // arrive while full, only the pop is accepted. When both arrive while
   // empty, only the write is accepted.
   assign empty = (wr_ptr_reg == rd_ptr_reg);
   assign full  = (wr_addr == rd_addr) &&
                  (wr_ptr_reg[ADDR_WIDTH] != rd_ptr_reg[ADDR_WIDTH]);

   assign wr_accept = w_en && !full;
   assign rd_accept = r_en && !empty;

   // The subtraction wraps modulo 2**(ADDR_WIDTH+1), so it stays correct
   // after either pointer wraps.
   assign count = wr_ptr_reg - rd_ptr_reg;

   // First-word-fall-through: the head entry is read combinationally.
   // The output is forced to zero while empty, so stale array data stays hidden.
   assign data_out = empty ? '0 : mem[rd_addr];

   always_ff @(posedge clk) begin
      if (!rst && wr_accept) begin
         mem[wr_addr] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (wr_accept) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (rd_accept) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
      end
   end

`ifdef ASYNCHRONIZE_FIFO_ERR_FLAGS_EN
   logic overflow_reg;
   logic underflow_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         if (w_en && full) begin
            overflow_reg <= 1'b1;
         end
         if (r_en && empty) begin
            underflow_reg <= 1'b1;
         end
      end
   end

   assign overflow  = overflow_reg;
   assign underflow = underflow_reg;
`endif

endmodule

// File: tb/tb_asynchronize_fifo.sv
// ---------------------------------------------------------------------------
// tb_asynchronize_fifo
//
// Directed self-checking bench for asynchronize_fifo with the default
// parameters (8 entries, 8-bit words). A queue holds the expected contents.
// The bench checks each expected head word, count and flag against the DUT.
// It also checks fixed values that were worked out by hand at the
// interesting points.
// ---------------------------------------------------------------------------
module tb_asynchronize_fifo;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       w_en = 1'b1;
   logic       r_en = 1'b0;
   logic [7:0] data_in = 8'hEE;
   logic [7:0] data_out;
   logic       full;
   logic       empty;
   logic [3:0] count;
`ifdef ASYNCHRONIZE_FIFO_ERR_FLAGS_EN
   logic       overflow;
   logic       underflow;
`endif

   int         total = 0;
   int         bad = 0;
   logic [7:0] q[$];

   always #5 clk = ~clk;

   asynchronize_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
      .clk      (clk),
      .rst      (rst),
      .w_en     (w_en),
      .r_en     (r_en),
      .data_in  (data_in),
      .data_out (data_out),
      .full     (full),
      .empty    (empty),
`ifdef ASYNCHRONIZE_FIFO_ERR_FLAGS_EN
      .count    (count),
      .overflow (overflow),
      .underflow(underflow)
`else
      .count    (count)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Runs one cycle with the given requests. Before the edge, it checks the
   // head word against the model. After the edge, it updates the model and
   // checks count, empty and full.
   task automatic do_cycle(input logic we, input logic re, input logic [7:0] din);
      bit wacc;
      bit racc;
      w_en    = we;
      r_en    = re;
      data_in = din;
      if (q.size() != 0) chk("head", 32'(data_out), 32'(q[0]));
      wacc = we && (q.size() < 8);
      racc = re && (q.size() > 0);
      step();
      if (racc) void'(q.pop_front());
      if (wacc) q.push_back(din);
      w_en = 1'b0;
      r_en = 1'b0;
      chk("count", 32'(count), 32'(q.size()));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("full", 32'(full), 32'(q.size() == 8));
      $display("cycle w=%0b r=%0b din=%02h -> count=%0d dout=%02h", we, re, din, count, data_out);
   endtask

   initial begin
      // Reset: hold rst for two cycles while w_en is also high.
      step();
      step();
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_dout", 32'(data_out), 32'd0);
      rst  = 1'b0;
      w_en = 1'b0;
      q.delete();

      // First-word-fall-through: write two words, then pop one.
      do_cycle(1'b1, 1'b0, 8'hA5);
      do_cycle(1'b1, 1'b0, 8'h3C);
      chk("fwft_head", 32'(data_out), 32'hA5);
      do_cycle(1'b0, 1'b1, 8'h00);
      chk("fwft_next", 32'(data_out), 32'h3C);
      chk("fwft_count", 32'(count), 32'd1);
      do_cycle(1'b0, 1'b1, 8'h00);

      // Full: write 01..08. The 9th write is dropped. Then drain in order.
      for (int i = 1; i <= 8; i++) do_cycle(1'b1, 1'b0, 8'(i));
      chk("full_flag", 32'(full), 32'd1);
      chk("full_count", 32'(count), 32'd8);
      do_cycle(1'b1, 1'b0, 8'hFF);
      chk("full_drop_count", 32'(count), 32'd8);
`ifdef ASYNCHRONIZE_FIFO_ERR_FLAGS_EN
      chk("overflow", 32'(overflow), 32'd1);
`endif
      for (int i = 1; i <= 8; i++) begin
         chk("drain", 32'(data_out), 32'(i));
         do_cycle(1'b0, 1'b1, 8'h00);
      end
      chk("drain_empty", 32'(empty), 32'd1);
      do_cycle(1'b0, 1'b1, 8'h00);
      chk("underrun_count", 32'(count), 32'd0);
`ifdef ASYNCHRONIZE_FIFO_ERR_FLAGS_EN
      chk("underflow", 32'(underflow), 32'd1);
`endif

      // Wrap-around: 30 cycles that alternate a write with a pop, using
      // random data.
      for (int k = 0; k < 30; k++) begin
         do_cycle(k % 2 == 0, k % 2 == 1, 8'($urandom_range(0, 255)));
      end

      // Simultaneous write and pop at a fill level of 4.
      for (int i = 0; i < 4; i++) do_cycle(1'b1, 1'b0, 8'($urandom_range(0, 255)));
      for (int i = 0; i < 10; i++) begin
         do_cycle(1'b1, 1'b1, 8'($urandom_range(0, 255)));
         chk("simul_count4", 32'(count), 32'd4);
      end

      // Both requests while full: only the pop is accepted.
      for (int i = 0; i < 4; i++) do_cycle(1'b1, 1'b0, 8'($urandom_range(0, 255)));
      do_cycle(1'b1, 1'b1, 8'hC3);
      chk("simul_full_count", 32'(count), 32'd7);

      // Both requests while empty: only the write is accepted.
      for (int i = 0; i < 7; i++) do_cycle(1'b0, 1'b1, 8'h00);
      do_cycle(1'b1, 1'b1, 8'h9A);
      chk("simul_empty_count", 32'(count), 32'd1);
      chk("simul_empty_dout", 32'(data_out), 32'h9A);

      // Reset in the middle of operation, at a fill level of 5.
      for (int i = 0; i < 4; i++) do_cycle(1'b1, 1'b0, 8'(8'h60 + i));
      chk("pre_rst_count", 32'(count), 32'd5);
      rst = 1'b1;
      step();
      rst = 1'b0;
      q.delete();
      chk("mid_rst_empty", 32'(empty), 32'd1);
      chk("mid_rst_count", 32'(count), 32'd0);
      chk("mid_rst_dout", 32'(data_out), 32'd0);
`ifdef ASYNCHRONIZE_FIFO_ERR_FLAGS_EN
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_underflow", 32'(underflow), 32'd0);
`endif
      do_cycle(1'b1, 1'b0, 8'h55);
      chk("post_rst_dout", 32'(data_out), 32'h55);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
